// File: rtl/tone_sequencer.sv
// tone_sequencer
// Queues note commands (half-period divider + length in beats) in a small
// FIFO and plays them back-to-back as a square wave on the left/right sample
// inputs of the audio output stage. Each note goes through one LOAD cycle
// (pop + counter setup, outputs 0) before its PLAY interval.
// A divider of 0 plays silence for the note length; a length of 0 drops the
// entry without playing it.

module tone_sequencer #(
    parameter int          DEPTH       = 4,
    parameter int          BEAT_CYCLES = 25000000,
    parameter logic [15:0] AMP         = 16'h2000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       note_valid,
    output logic                       note_ready,
    input  logic [21:0]                note_div,
    input  logic [7:0]                 note_len,
    input  logic                       stop,
    output logic [15:0]                audio_left,
    output logic [15:0]                audio_right,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BEAT_W  = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int ENTRY_W = 22 + 8;

    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(DEPTH);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [15:0]       NEG_AMP   = ~AMP + 16'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Note FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic [21:0]        head_div;
    logic [7:0]         head_len;

    state_t             state_reg;

    // note_ready deliberately ignores a same-cycle pop so the accept path
    // stays independent of the playback state.
    assign note_ready = (count_reg < FIFO_FULL) && !stop;
    assign push       = note_valid && note_ready;
    assign pop        = (state_reg == LOAD) && !stop;

    // The head entry is read combinationally so LOAD can both pop it and
    // decide the next state within its single cycle.
    assign head     = mem[rd_ptr_reg];
    assign head_div = head[ENTRY_W-1:8];
    assign head_len = head[7:0];

    // Occupancy after this cycle's push/pop (stop handled separately)
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Entry storage: no reset, contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {note_div, note_len};
        end
    end

    // Pointers and occupancy; stop flushes the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (stop) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    assign fifo_count = count_reg;

    // ------------------------------------------------------------------
    // Playback FSM
    // ------------------------------------------------------------------
    logic [21:0]        cur_div_reg;
    logic [21:0]        tone_cnt_reg;
    logic [BEAT_W-1:0]  beat_cnt_reg;
    logic [7:0]         beats_left_reg;
    logic               phase_reg;
    logic [15:0]        audio_reg;

    // Sequencer: IDLE waits for a queued note, LOAD pops it and primes the
    // counters, PLAY generates the square wave and counts beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cur_div_reg    <= '0;
            tone_cnt_reg   <= '0;
            beat_cnt_reg   <= '0;
            beats_left_reg <= '0;
            phase_reg      <= 1'b1;
            audio_reg      <= '0;
        end else if (stop) begin
            state_reg      <= IDLE;
            tone_cnt_reg   <= '0;
            beat_cnt_reg   <= '0;
            beats_left_reg <= '0;
            phase_reg      <= 1'b1;
            audio_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    audio_reg <= '0;
                    if (count_reg != '0) begin
                        state_reg <= LOAD;
                    end
                end

                LOAD: begin
                    cur_div_reg    <= head_div;
                    tone_cnt_reg   <= '0;
                    beat_cnt_reg   <= '0;
                    beats_left_reg <= head_len;
                    phase_reg      <= 1'b1;
                    if (head_len == 8'd0) begin
                        // Zero-length note: drop it and move straight on
                        audio_reg <= '0;
                        state_reg <= (count_next != '0) ? LOAD : IDLE;
                    end else begin
                        audio_reg <= (head_div != 22'd0) ? AMP : '0;
                        state_reg <= PLAY;
                    end
                end

                PLAY: begin
                    // Tone generator: half-period of cur_div cycles
                    if (cur_div_reg != 22'd0) begin
                        if (tone_cnt_reg == cur_div_reg - 22'd1) begin
                            tone_cnt_reg <= '0;
                            phase_reg    <= ~phase_reg;
                            // Output follows the new phase value
                            audio_reg    <= phase_reg ? NEG_AMP : AMP;
                        end else begin
                            tone_cnt_reg <= tone_cnt_reg + 22'd1;
                        end
                    end else begin
                        audio_reg <= '0;
                    end

                    // Beat counter; the last beat wrap ends the note and
                    // overrides the tone output with silence.
                    if (beat_cnt_reg == BEAT_LAST) begin
                        beat_cnt_reg   <= '0;
                        beats_left_reg <= beats_left_reg - 8'd1;
                        if (beats_left_reg == 8'd1) begin
                            audio_reg <= '0;
                            state_reg <= (count_next != '0) ? LOAD : IDLE;
                        end
                    end else begin
                        beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    audio_reg <= '0;
                end
            endcase
        end
    end

    assign audio_left  = audio_reg;
    assign audio_right = audio_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed testbench for tone_sequencer (BEAT_CYCLES=8, DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.

module tb_tone_sequencer;

    logic        clk;
    logic        rst;
    logic        note_valid;
    logic        note_ready;
    logic [21:0] note_div;
    logic [7:0]  note_len;
    logic        stop;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic        busy;
    logic [2:0]  fifo_count;

    int n_assert;
    int n_fail;

    tone_sequencer #(
        .DEPTH       (4),
        .BEAT_CYCLES (8),
        .AMP         (16'h2000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .note_div    (note_div),
        .note_len    (note_len),
        .stop        (stop),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_note(input logic [21:0] d, input logic [7:0] l);
        note_valid = 1'b1;
        note_div   = d;
        note_len   = l;
    endtask

    task automatic clr_note();
        note_valid = 1'b0;
        note_div   = '0;
        note_len   = '0;
    endtask

    // Starting at the first PLAY sample, check len*8 samples of a square
    // wave with half-period div (+AMP first), stepping one cycle per sample.
    // Returns positioned at the sample after the note's last edge.
    task automatic play_check(input string tag, input int div, input int len);
        logic [15:0] e;
        for (int k = 0; k < len * 8; k++) begin
            if (div == 0) e = 16'h0000;
            else          e = (((k / div) % 2) == 0) ? 16'h2000 : 16'hE000;
            chk($sformatf("%s_left_k%0d", tag, k), {16'h0, audio_left}, {16'h0, e});
            chk($sformatf("%s_right_k%0d", tag, k), {16'h0, audio_right}, {16'h0, e});
            chk($sformatf("%s_busy_k%0d", tag, k), {31'h0, busy}, 32'd1);
            step();
        end
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        stop       = 1'b0;
        note_valid = 1'b0;
        note_div   = '0;
        note_len   = '0;

        // 1. Reset then idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t1_left",  {16'h0, audio_left},  32'h0);
        chk("t1_right", {16'h0, audio_right}, 32'h0);
        chk("t1_ready", {31'h0, note_ready},  32'd1);
        chk("t1_count", {29'h0, fifo_count},  32'd0);
        chk("t1_busy",  {31'h0, busy},        32'd0);
        step();

        // 2. Single note div=3 len=2
        set_note(22'd3, 8'd2);
        step();
        clr_note();
        chk("t2_queued_count", {29'h0, fifo_count}, 32'd1);
        chk("t2_queued_busy",  {31'h0, busy},       32'd0);
        step();
        chk("t2_load_busy",  {31'h0, busy},       32'd1);
        chk("t2_load_audio", {16'h0, audio_left}, 32'h0);
        step();
        play_check("t2", 3, 2);
        chk("t2_end_audio", {16'h0, audio_left}, 32'h0);
        chk("t2_end_busy",  {31'h0, busy},       32'd0);
        chk("t2_end_count", {29'h0, fifo_count}, 32'd0);

        // 3. Fill the FIFO while a rest note plays, then check order
        set_note(22'd0, 8'd2);        // A: rest, 16 cycles
        step();
        clr_note();
        step();                        // LOAD
        step();                        // first PLAY sample of A
        chk("t3_a_busy", {31'h0, busy}, 32'd1);
        set_note(22'd1, 8'd1); step(); // B
        chk("t3_count1", {29'h0, fifo_count}, 32'd1);
        set_note(22'd2, 8'd1); step(); // C
        chk("t3_count2", {29'h0, fifo_count}, 32'd2);
        set_note(22'd3, 8'd1); step(); // D
        chk("t3_count3", {29'h0, fifo_count}, 32'd3);
        set_note(22'd4, 8'd1); step(); // E
        chk("t3_count4", {29'h0, fifo_count}, 32'd4);
        chk("t3_ready_full", {31'h0, note_ready}, 32'd0);
        set_note(22'd9, 8'd1); step(); // F must be refused
        clr_note();
        chk("t3_count_refused", {29'h0, fifo_count}, 32'd4);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("t3_a_rest_%0d", i), {16'h0, audio_left}, 32'h0);
            step();
        end
        chk("t3_loadb_audio", {16'h0, audio_left}, 32'h0);
        chk("t3_loadb_busy",  {31'h0, busy},       32'd1);
        chk("t3_loadb_count", {29'h0, fifo_count}, 32'd4);
        step();
        chk("t3_b_count", {29'h0, fifo_count}, 32'd3);
        play_check("t3_b", 1, 1);
        chk("t3_loadc_audio", {16'h0, audio_left}, 32'h0);
        step();
        play_check("t3_c", 2, 1);
        chk("t3_loadd_audio", {16'h0, audio_left}, 32'h0);
        step();
        play_check("t3_d", 3, 1);
        chk("t3_loade_audio", {16'h0, audio_left}, 32'h0);
        step();
        play_check("t3_e", 4, 1);
        chk("t3_end_busy",  {31'h0, busy},       32'd0);
        chk("t3_end_count", {29'h0, fifo_count}, 32'd0);
        chk("t3_end_audio", {16'h0, audio_left}, 32'h0);

        // 4. Rest note followed by div=2 tone
        set_note(22'd0, 8'd1); step();
        set_note(22'd2, 8'd1); step();
        clr_note();
        step();
        play_check("t4_rest", 0, 1);
        chk("t4_load_audio", {16'h0, audio_left}, 32'h0);
        chk("t4_load_busy",  {31'h0, busy},       32'd1);
        step();
        play_check("t4_tone", 2, 1);
        chk("t4_end_busy", {31'h0, busy}, 32'd0);

        // 5. Zero-length entry discarded, then div=4 tone
        set_note(22'd7, 8'd0); step();
        set_note(22'd4, 8'd1); step(); // first LOAD
        clr_note();
        chk("t5_load1_audio", {16'h0, audio_left}, 32'h0);
        chk("t5_load1_busy",  {31'h0, busy},       32'd1);
        step();                         // second LOAD
        chk("t5_load2_audio", {16'h0, audio_left}, 32'h0);
        chk("t5_load2_busy",  {31'h0, busy},       32'd1);
        chk("t5_load2_count", {29'h0, fifo_count}, 32'd1);
        step();
        play_check("t5_tone", 4, 1);
        chk("t5_end_busy", {31'h0, busy}, 32'd0);

        // 6. stop mid-PLAY with two notes queued and a simultaneous push
        set_note(22'd2, 8'd4); step();
        set_note(22'd5, 8'd1); step();
        set_note(22'd6, 8'd1); step();
        clr_note();
        chk("t6_play_count", {29'h0, fifo_count}, 32'd2);
        chk("t6_play_audio", {16'h0, audio_left}, 32'h2000);
        step();
        step();
        chk("t6_play_audio2", {16'h0, audio_left}, 32'hE000);
        stop = 1'b1;
        set_note(22'd7, 8'd1);
        #1;
        chk("t6_ready_stop", {31'h0, note_ready}, 32'd0);
        step();
        stop = 1'b0;
        clr_note();
        chk("t6_stop_count", {29'h0, fifo_count}, 32'd0);
        chk("t6_stop_audio", {16'h0, audio_left}, 32'h0);
        chk("t6_stop_busy",  {31'h0, busy},       32'd0);
        step();
        chk("t6_after_count", {29'h0, fifo_count}, 32'd0);
        chk("t6_after_busy",  {31'h0, busy},       32'd0);

        // 6b. rst asserted mid-note
        set_note(22'd2, 8'd2); step();
        set_note(22'd3, 8'd1); step();
        clr_note();
        step();
        chk("t6_rst_pre_audio", {16'h0, audio_left}, 32'h2000);
        chk("t6_rst_pre_count", {29'h0, fifo_count}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_left",  {16'h0, audio_left},  32'h0);
        chk("t6_rst_right", {16'h0, audio_right}, 32'h0);
        chk("t6_rst_busy",  {31'h0, busy},        32'd0);
        chk("t6_rst_count", {29'h0, fifo_count},  32'd0);
        #1 rst = 1'b0;
        step();
        chk("t6_post_busy",  {31'h0, busy},       32'd0);
        chk("t6_post_count", {29'h0, fifo_count}, 32'd0);
        chk("t6_post_ready", {31'h0, note_ready}, 32'd1);
        step();
        chk("t6_post2_busy",  {31'h0, busy},       32'd0);
        chk("t6_post2_audio", {16'h0, audio_left}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
